cond_logic_pipe: RTL and testbench

//  Parametrised, registered successor of the single-cycle conditional-execution unit.

---
 rtl/cond_pkg.sv | 41 ++++
 rtl/cond_check.sv | 12 +
 rtl/cond_logic_pipe.sv | 111 +++++++++++
 tb/tb_cond_logic_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Condition-code definitions shared by the conditional-execution pipeline stage.
// cond_eval gives the pass/fail result of an ARM condition field for a given NZCV set.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;

    localparam int unsigned N_IDX = 3;
    localparam int unsigned Z_IDX = 2;
    localparam int unsigned C_IDX = 1;
    localparam int unsigned V_IDX = 0;

    function automatic logic cond_eval(cond_e cond, logic [3:0] flags);
        logic n, z, c, v;
        n = flags[N_IDX];
        z = flags[Z_IDX];
        c = flags[C_IDX];
        v = flags[V_IDX];
        cond_eval = 1'b0;
        case (cond)
            EQ:      cond_eval = z;
            NE:      cond_eval = ~z;
            CS:      cond_eval = c;
            CC:      cond_eval = ~c;
            MI:      cond_eval = n;
            PL:      cond_eval = ~n;
            VS:      cond_eval = v;
            VC:      cond_eval = ~v;
            HI:      cond_eval = c & ~z;
            LS:      cond_eval = ~c | z;
            GE:      cond_eval = (n == v);
            LT:      cond_eval = (n != v);
            GT:      cond_eval = ~z & (n == v);
            LE:      cond_eval = z | (n != v);
            AL:      cond_eval = 1'b1;
            default: cond_eval = 1'b0;  // NV never executes
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational condition checker: passes when the stored flags satisfy the condition field.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       ce
);

    assign ce = cond_eval(cond_e'(cond), flags);

endmodule

// File: rtl/cond_logic_pipe.sv
// Registered conditional-execution stage: grouped NZCV storage, gated write enables,
// stall/flush control and saturating executed/skipped counters.
module cond_logic_pipe
    import cond_pkg::*;
#(
    parameter int unsigned FLAG_GROUPS = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned REG_OUT     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [3:0]             Cond,
    input  logic [3:0]             ALUFlags,
    input  logic [FLAG_GROUPS-1:0] FlagW,
    input  logic                   PCS,
    input  logic                   RegW,
    input  logic                   MemW,
    input  logic                   NoWrite,
    output logic                   PCSrc,
    output logic                   RegWrite,
    output logic                   MemWrite,
    output logic                   CondEx,
    output logic [3:0]             Flags,
    output logic [CNT_W-1:0]       exec_cnt,
    output logic [CNT_W-1:0]       skip_cnt
);

    localparam int unsigned GRP_W = 4 / FLAG_GROUPS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (FLAG_GROUPS != 1 && FLAG_GROUPS != 2 && FLAG_GROUPS != 4) begin : g_bad_groups
        $error("cond_logic_pipe: FLAG_GROUPS must be 1, 2 or 4");
    end

    logic [3:0]       flags;
    logic             acc;
    logic             ce;
    logic             pcs, rw, mw, cx;
    logic [CNT_W-1:0] exec_q, skip_q;

    // Holding reset also blocks acceptance so the combinational variant reads 0 in reset.
    assign acc = valid & ~stall & ~flush & reset;

    cond_check u_cond_check (
        .cond  (Cond),
        .flags (flags),
        .ce    (ce)
    );

    for (genvar g = 0; g < FLAG_GROUPS; g++) begin : g_grp
        logic [GRP_W-1:0] grp_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                grp_q <= '0;
            end else if (acc && ce && FlagW[g]) begin
                grp_q <= ALUFlags[g*GRP_W +: GRP_W];
            end
        end

        assign flags[g*GRP_W +: GRP_W] = grp_q;
    end

    assign Flags = flags;

    always_comb begin
        pcs = PCS & ce & acc;
        rw  = RegW & ce & ~NoWrite & acc;
        mw  = MemW & ce & acc;
        cx  = ce & acc;
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [3:0] out_q;

        // A flush (with or without stall) loads zeros because acc is low.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                out_q <= '0;
            end else if (!stall || flush) begin
                out_q <= {pcs, rw, mw, cx};
            end
        end

        assign {PCSrc, RegWrite, MemWrite, CondEx} = out_q;
    end else begin : g_comb_out
        assign {PCSrc, RegWrite, MemWrite, CondEx} = {pcs, rw, mw, cx};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (acc) begin
            if (ce) begin
                if (exec_q != CNT_MAX) begin
                    exec_q <= exec_q + CNT_W'(1);
                end
            end else if (skip_q != CNT_MAX) begin
                skip_q <= skip_q + CNT_W'(1);
            end
        end
    end

    assign exec_cnt = exec_q;
    assign skip_cnt = skip_q;

endmodule

// File: tb/tb_cond_logic_pipe.sv
// Bench for cond_logic_pipe: a registered 2-group/16-bit instance and a combinational
// 4-group/4-bit instance share stimulus and are checked against a behavioural model.
module tb_cond_logic_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [3:0] cond = 4'b0, alu = 4'b0;
    logic [1:0] fw_a = 2'b0;
    logic [3:0] fw_b = 4'b0;
    logic       pcs = 1'b0, regw = 1'b0, memw = 1'b0, nowr = 1'b0;

    logic        a_pcsrc, a_regw, a_memw, a_condex;
    logic [3:0]  a_flags;
    logic [15:0] a_exec, a_skip;
    logic        b_pcsrc, b_regw, b_memw, b_condex;
    logic [3:0]  b_flags;
    logic [3:0]  b_exec, b_skip;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    cond_logic_pipe #(.FLAG_GROUPS(2), .CNT_W(16), .REG_OUT(1)) dut_a (
        .clk(clk), .reset(reset), .valid(valid), .stall(stall), .flush(flush),
        .Cond(cond), .ALUFlags(alu), .FlagW(fw_a), .PCS(pcs), .RegW(regw), .MemW(memw),
        .NoWrite(nowr), .PCSrc(a_pcsrc), .RegWrite(a_regw), .MemWrite(a_memw),
        .CondEx(a_condex), .Flags(a_flags), .exec_cnt(a_exec), .skip_cnt(a_skip)
    );

    cond_logic_pipe #(.FLAG_GROUPS(4), .CNT_W(4), .REG_OUT(0)) dut_b (
        .clk(clk), .reset(reset), .valid(valid), .stall(stall), .flush(flush),
        .Cond(cond), .ALUFlags(alu), .FlagW(fw_b), .PCS(pcs), .RegW(regw), .MemW(memw),
        .NoWrite(nowr), .PCSrc(b_pcsrc), .RegWrite(b_regw), .MemWrite(b_memw),
        .CondEx(b_condex), .Flags(b_flags), .exec_cnt(b_exec), .skip_cnt(b_skip)
    );

    // Conditions come in complementary pairs; the odd member inverts the even one.
    function automatic logic passes(logic [3:0] c, logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [3:0] upd(logic [3:0] old, logic [3:0] a, logic [3:0] w,
                                       int groups, logic en);
        logic [3:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (en && w[i / (4 / groups)]) r[i] = a[i];
        end
        return r;
    endfunction

    function automatic logic [3:0] gated(logic a, logic c, logic p, logic r, logic m,
                                         logic nw);
        return {p && c && a, r && c && !nw && a, m && c && a, c && a};
    endfunction

    function automatic int sat(int x, int mx);
        return (x < mx) ? x + 1 : x;
    endfunction

    logic [3:0] m_flags_a = 4'b0, m_flags_b = 4'b0, m_out_a = 4'b0;
    int m_exec_a = 0, m_skip_a = 0, m_exec_b = 0, m_skip_b = 0;

    wire acc_m = valid && !stall && !flush && reset;
    wire ce_ma = passes(cond, m_flags_a);
    wire ce_mb = passes(cond, m_flags_b);
    wire [3:0] exp_b_out = gated(acc_m, ce_mb, pcs, regw, memw, nowr);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_flags_a <= 4'b0;
            m_flags_b <= 4'b0;
            m_out_a   <= 4'b0;
            m_exec_a  <= 0;
            m_skip_a  <= 0;
            m_exec_b  <= 0;
            m_skip_b  <= 0;
        end else begin
            if (!stall || flush) m_out_a <= gated(acc_m, ce_ma, pcs, regw, memw, nowr);
            if (acc_m) begin
                m_flags_a <= upd(m_flags_a, alu, {2'b00, fw_a}, 2, ce_ma);
                m_flags_b <= upd(m_flags_b, alu, fw_b, 4, ce_mb);
                if (ce_ma) m_exec_a <= sat(m_exec_a, 65535);
                else       m_skip_a <= sat(m_skip_a, 65535);
                if (ce_mb) m_exec_b <= sat(m_exec_b, 15);
                else       m_skip_b <= sat(m_skip_b, 15);
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_out",   {28'd0, a_pcsrc, a_regw, a_memw, a_condex}, {28'd0, m_out_a});
            chk("a_flags", {28'd0, a_flags}, {28'd0, m_flags_a});
            chk("a_exec",  {16'd0, a_exec}, m_exec_a);
            chk("a_skip",  {16'd0, a_skip}, m_skip_a);
            chk("b_out",   {28'd0, b_pcsrc, b_regw, b_memw, b_condex}, {28'd0, exp_b_out});
            chk("b_flags", {28'd0, b_flags}, {28'd0, m_flags_b});
            chk("b_exec",  {28'd0, b_exec}, m_exec_b);
            chk("b_skip",  {28'd0, b_skip}, m_skip_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set(logic [3:0] c, logic [3:0] a, logic [1:0] wa, logic [3:0] wb,
                       logic p, logic r, logic m, logic nw);
        valid = 1'b1; stall = 1'b0; flush = 1'b0;
        cond = c; alu = a; fw_a = wa; fw_b = wb;
        pcs = p; regw = r; memw = m; nowr = nw;
    endtask

    initial begin
        #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) tick();
        chk("rst_flags", {28'd0, a_flags}, 32'd0);
        chk("rst_exec", {16'd0, a_exec}, 32'd0);

        // Reset mid-stream with valid instructions in flight
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set(4'b1110, 4'($urandom), 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
        end
        reset = 1'b0;
        #1;
        chk("rst_mid_condex", {31'd0, a_condex}, 32'd0);
        chk("rst_mid_regw", {31'd0, a_regw}, 32'd0);
        chk("rst_mid_flags", {28'd0, a_flags}, 32'd0);
        chk("rst_mid_exec", {16'd0, a_exec}, 32'd0);
        chk("rst_mid_b_condex", {31'd0, b_condex}, 32'd0);
        tick();
        reset = 1'b1;
        set(4'b1110, 4'b0000, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("first_al_condex", {31'd0, a_condex}, 32'd1);
        chk("first_al_exec", {16'd0, a_exec}, 32'd1);

        // CMP sets Z, then BEQ takes the branch
        set(4'b1110, 4'b0100, 2'b11, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("cmp_flags", {28'd0, a_flags}, 32'h4);
        chk("cmp_regw", {31'd0, a_regw}, 32'd0);
        set(4'b0000, 4'b0000, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("beq_pcsrc", {31'd0, a_pcsrc}, 32'd1);

        // ADDEQ sees stored flags 0000, not the live Z
        set(4'b1110, 4'b0000, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set(4'b0000, 4'b0100, 2'b11, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("addeq_regw", {31'd0, a_regw}, 32'd0);
        chk("addeq_flags", {28'd0, a_flags}, 32'd0);
        chk("addeq_skip", {16'd0, a_skip}, 32'd1);
        chk("addeq_exec", {16'd0, a_exec}, 32'd4);

        // Partial group write: only the low group (C,V) is updated
        set(4'b1110, 4'b1111, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set(4'b1110, 4'b0000, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("partial_a_flags", {28'd0, a_flags}, 32'hC);
        chk("partial_b_flags", {28'd0, b_flags}, 32'hC);

        // Stall freezes everything
        set(4'b1110, 4'b0101, 2'b11, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set(4'b1110, 4'b1010, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_regw", {31'd0, a_regw}, 32'd1);
            chk("stall_flags", {28'd0, a_flags}, 32'h5);
            chk("stall_exec", {16'd0, a_exec}, 32'd7);
        end
        set(4'b1110, 4'b0000, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        chk("flush_memw", {31'd0, a_memw}, 32'd0);
        chk("flush_exec", {16'd0, a_exec}, 32'd7);
        chk("flush_skip", {16'd0, a_skip}, 32'd1);
        set(4'b1110, 4'b0000, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("pre_sf_regw", {31'd0, a_regw}, 32'd1);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("sf_regw", {31'd0, a_regw}, 32'd0);
        chk("sf_condex", {31'd0, a_condex}, 32'd0);
        chk("sf_exec", {16'd0, a_exec}, 32'd8);

        // Saturation of the 4-bit counter, then NV
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set(4'b1110, 4'b0000, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) tick();
        chk("sat_b_exec", {28'd0, b_exec}, 32'd15);
        chk("sat_a_exec", {16'd0, a_exec}, 32'd20);
        set(4'b1111, 4'b1111, 2'b11, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("nv_regw", {31'd0, a_regw}, 32'd0);
        chk("nv_skip", {16'd0, a_skip}, 32'd1);
        chk("nv_b_skip", {28'd0, b_skip}, 32'd1);
        chk("nv_flags", {28'd0, a_flags}, 32'd0);

        // Randomized traffic with occasional stall, flush and reset
        for (int i = 0; i < 3000; i++) begin
            valid = ($urandom_range(0, 9) < 8);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            cond  = 4'($urandom);
            alu   = 4'($urandom);
            fw_a  = 2'($urandom);
            fw_b  = 4'($urandom);
            pcs   = 1'($urandom);
            regw  = 1'($urandom);
            memw  = 1'($urandom);
            nowr  = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset = 1'b1;
        valid = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
